// File: rtl/serial_pattern_tx.sv
// Serial bit-stream transmitter: captures a parallel word on start and shifts it
// out one bit per clk_2, MSB- or LSB-first, with busy/done and a 7-segment count.
module serial_pattern_tx #(
  parameter int unsigned NBITS = 8
) (
  input  logic             clk_2,
  input  logic             reset,
  input  logic             start,
  input  logic [NBITS-1:0] data,
  input  logic             lsb_first,
  output logic             ser_out,
  output logic             busy,
  output logic             done,
  output logic [3:0]       remaining,
  output logic [7:0]       seg
);

  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

  state_t           state, state_d;
  logic [NBITS-1:0] shreg, shreg_d;
  logic             order, order_d;
  logic [3:0]       rem_q, rem_d;

  always_ff @(posedge clk_2 or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      shreg <= '0;
      order <= 1'b0;
      rem_q <= '0;
    end else begin
      state <= state_d;
      shreg <= shreg_d;
      order <= order_d;
      rem_q <= rem_d;
    end
  end

  always_comb begin
    state_d = state;
    shreg_d = shreg;
    order_d = order;
    rem_d   = rem_q;
    case (state)
      IDLE: begin
        if (start) begin
          state_d = SEND;
          shreg_d = data;
          order_d = lsb_first;
          rem_d   = 4'(NBITS);
        end
      end
      SEND: begin
        // Shift toward whichever end is being transmitted.
        shreg_d = order ? (shreg >> 1) : (shreg << 1);
        if (rem_q == 4'd1) begin
          state_d = DONE;
          rem_d   = '0;
        end else begin
          rem_d = rem_q - 4'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ser_out   = (state == SEND) && (order ? shreg[0] : shreg[NBITS-1]);
    busy      = (state == SEND);
    done      = (state == DONE);
    remaining = rem_q;
    case (rem_q)
      4'h0: seg = 8'h3F;
      4'h1: seg = 8'h06;
      4'h2: seg = 8'h5B;
      4'h3: seg = 8'h4F;
      4'h4: seg = 8'h66;
      4'h5: seg = 8'h6D;
      4'h6: seg = 8'h7D;
      4'h7: seg = 8'h07;
      4'h8: seg = 8'h7F;
      4'h9: seg = 8'h6F;
      4'hA: seg = 8'h77;
      4'hB: seg = 8'h7C;
      4'hC: seg = 8'h39;
      4'hD: seg = 8'h5E;
      4'hE: seg = 8'h79;
      default: seg = 8'h71;
    endcase
  end

endmodule
